mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle main controller for the MIPS core; replaces single-cycle combinational decode with a Moore/Mealy FSM.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single unified memory port with a ready handshake.
- Supports addu, subu, ori, lw, sw, beq and j.
- Sits between the IR opcode/func fields and the datapath muxes and enables.

Parameters:
- TIMEOUT, 16, consecutive cycles a memory access may wait on mem_ready=0 before aborting with bus_err.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH.
- func  in  6  IR[5:0].
- zero  in  1  ALU equality result.
- mem_ready  in  1  memory completes the current access this cycle.
- IRWrite  out  1  load IR.
- PCWrite  out  1  load PC.
- PCSrc  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address.
- IorD  out  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- RegWrite  out  1  register file write enable.
- RegDst  out  2  destination register: 00 = rt, 01 = rd.
- DatatoReg  out  2  writeback source: 00 = ALUOut, 01 = MDR.
- ALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B operand: 00 = rt, 01 = const 4, 10 = ext imm, 11 = sext imm<<2.
- ExtOp  out  1  immediate extension: 1 = sign, 0 = zero.
- ALUCtrl  out  5  ALUOp_ADDU / ALUOp_SUBU / ALUOp_OR / ALUOp_EQL codes.
- state  out  4  current state, for debug.
- illegal  out  1  one-cycle pulse on an unsupported instruction.
- bus_err  out  1  one-cycle pulse on a memory timeout.

Behaviour:
- Reset: on rst=1 at a clock edge, state <= IDLE and wait counter <= 0; a reset mid-access abandons it. In IDLE every output is 0, ALUCtrl = ALUOp_ADDU, and the FSM moves unconditionally to FETCH.
- Defaults: any output not listed for a state is 0; RegDst = DatatoReg = PCSrc = 00.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtrl=ADDU.
  - IRWrite = PCWrite = mem_ready (Mealy).
  - Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ExtOp=1, ALUCtrl=ADDU (branch target into ALUOut).
  - Next state by opcode/func:
    - 000000 with func 100001 (addu) or 100011 (subu) -> EXEC_R.
    - 001101 (ori) -> EXEC_I.
    - 100011 (lw) or 101011 (sw) -> MEM_ADR.
    - 000100 (beq) -> BRANCH.
    - 000010 (j) -> JUMP.
    - Anything else -> illegal=1 this cycle, -> FETCH. The instruction is treated as a nop; PC is already advanced.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUCtrl = ADDU or SUBU by func -> ALU_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUCtrl=OR -> ALU_WB.
- ALU_WB: RegWrite=1, RegDst = 01 if opcode==000000 else 00, DatatoReg=00 -> FETCH.
- MEM_ADR: ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUCtrl=ADDU -> MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead=1, IorD=1; waits on mem_ready -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, DatatoReg=01 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; waits on mem_ready -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUCtrl=EQL, PCSrc=01, PCWrite=zero -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Wait counter:
  - Applies in FETCH, MEM_RD and MEM_WR.
  - Increments each cycle mem_ready=0; clears on every state change.
  - If it reaches TIMEOUT with mem_ready still 0: bus_err=1 for that cycle and -> IDLE, so a FETCH retries the same PC.
  - No IRWrite, PCWrite, RegWrite or MemWrite commit occurs on a timeout cycle.
  - If mem_ready=1 arrives on the timeout cycle, mem_ready wins and normal completion proceeds.
- Latency with mem_ready always 1: R-type/ori 4 cycles, lw 5, sw 4, beq 3, j 3, illegal 2.
- MemRead and MemWrite are never both 1. At most one of IRWrite, RegWrite, MemWrite is asserted per cycle.

Test Plan:
- Reset, then addu (op 000000, func 100001), mem_ready=1 -> states IDLE, FETCH, DECODE, EXEC_R, ALU_WB, FETCH; RegWrite=1 and RegDst=01 only in ALU_WB; 4 cycles from FETCH back to FETCH.
- lw (100011) with mem_ready low for 3 cycles in MEM_RD -> MemRead=1, IorD=1 held for 4 cycles; then MEM_WB with DatatoReg=01 and RegWrite=1; no bus_err.
- beq (000100) with zero=1 -> PCWrite=1, PCSrc=01 in BRANCH; with zero=0 -> PCWrite=0; both return to FETCH after 3 cycles.
- Opcode 111111, and separately op 000000 with func 000000 -> illegal pulses exactly 1 cycle in DECODE; next state is FETCH; no RegWrite or MemWrite asserted.
- sw (101011) with mem_ready held 0 -> bus_err=1 on the 16th wait cycle; next state IDLE, then FETCH; MemWrite drops and no PCWrite occurs.
- rst asserted during MEM_WR -> next cycle state=IDLE with all outputs 0, and the wait counter is cleared.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Opcode/handshake inputs and datapath control outputs of the multi-cycle controller.
// master = controller side, slave = datapath/memory side.
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic [5:0] func;
    logic       zero;
    logic       mem_ready;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] DatatoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [4:0] ALUCtrl;
    logic [3:0] state;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  opcode, func, zero, mem_ready,
        output IRWrite, PCWrite, PCSrc, IorD, MemRead, MemWrite, RegWrite,
               RegDst, DatatoReg, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, state,
               illegal, bus_err
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  IRWrite, PCWrite, PCSrc, IorD, MemRead, MemWrite, RegWrite,
               RegDst, DatatoReg, ALUSrcA, ALUSrcB, ExtOp, ALUCtrl, state,
               illegal, bus_err
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS main controller (addu/subu/ori/lw/sw/beq/j); 2-5 cycles per instruction.
// Memory states stall on mem_ready=0 and abort to IDLE with bus_err after TIMEOUT waits.
module mc_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_ALU_WB  = 4'd5,
        S_MEM_ADR = 4'd6,
        S_MEM_RD  = 4'd7,
        S_MEM_WB  = 4'd8,
        S_MEM_WR  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [4:0] ALUOP_ADDU = 5'd1;
    localparam logic [4:0] ALUOP_SUBU = 5'd2;
    localparam logic [4:0] ALUOP_OR   = 5'd3;
    localparam logic [4:0] ALUOP_EQL  = 5'd4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;

    state_t           cur, nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_st;
    logic             timeout;

    assign wait_st = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
    // Timeout fires on the TIMEOUT-th consecutive stalled cycle; a late mem_ready still wins.
    assign timeout = wait_st && !bus.mem_ready && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) cur <= S_IDLE;
        else     cur <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst || (nxt != cur))               wait_cnt <= '0;
        else if (wait_st && !bus.mem_ready)    wait_cnt <= wait_cnt + CNT_W'(1);
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:    nxt = S_FETCH;
            S_FETCH:   if (bus.mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_IDLE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_R:         nxt = (bus.func == FN_ADDU || bus.func == FN_SUBU) ? S_EXEC_R : S_FETCH;
                    OP_ORI:       nxt = S_EXEC_I;
                    OP_LW, OP_SW: nxt = S_MEM_ADR;
                    OP_BEQ:       nxt = S_BRANCH;
                    OP_J:         nxt = S_JUMP;
                    default:      nxt = S_FETCH;
                endcase
            end
            S_EXEC_R:  nxt = S_ALU_WB;
            S_EXEC_I:  nxt = S_ALU_WB;
            S_ALU_WB:  nxt = S_FETCH;
            S_MEM_ADR: nxt = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (bus.mem_ready) nxt = S_MEM_WB; else if (timeout) nxt = S_IDLE;
            S_MEM_WB:  nxt = S_FETCH;
            S_MEM_WR:  if (bus.mem_ready) nxt = S_FETCH; else if (timeout) nxt = S_IDLE;
            S_BRANCH:  nxt = S_FETCH;
            S_JUMP:    nxt = S_FETCH;
            default:   nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.PCSrc     = 2'b00;
        bus.IorD      = 1'b0;
        bus.MemRead   = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.RegDst    = 2'b00;
        bus.DatatoReg = 2'b00;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = 2'b00;
        bus.ExtOp     = 1'b0;
        bus.ALUCtrl   = ALUOP_ADDU;
        bus.illegal   = 1'b0;
        bus.state     = cur;
        bus.bus_err   = timeout;
        case (cur)
            S_FETCH: begin
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                bus.ExtOp   = 1'b1;
                bus.illegal = (nxt == S_FETCH);
            end
            S_EXEC_R: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUCtrl = (bus.func == FN_SUBU) ? ALUOP_SUBU : ALUOP_ADDU;
            end
            S_EXEC_I: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ALUCtrl = ALUOP_OR;
            end
            S_ALU_WB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = (bus.opcode == OP_R) ? 2'b01 : 2'b00;
            end
            S_MEM_ADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                bus.ExtOp   = 1'b1;
            end
            S_MEM_RD: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end
            S_MEM_WB: begin
                bus.RegWrite  = 1'b1;
                bus.DatatoReg = 2'b01;
            end
            S_MEM_WR: begin
                bus.MemWrite = !timeout;
                bus.IorD     = 1'b1;
            end
            S_BRANCH: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUCtrl = ALUOP_EQL;
                bus.PCSrc   = 2'b01;
                bus.PCWrite = bus.zero;
            end
            S_JUMP: begin
                bus.PCSrc   = 2'b10;
                bus.PCWrite = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each cycle's expected control word is queued by the
// stimulus and compared by an independent negedge monitor.
module tb_mc_ctrl;
    localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC_R = 4'd3,
                           S_EXEC_I = 4'd4, S_ALU_WB = 4'd5, S_MEM_ADR = 4'd6, S_MEM_RD = 4'd7,
                           S_MEM_WB = 4'd8, S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP = 4'd11;
    localparam logic [4:0] A_ADDU = 5'd1, A_SUBU = 5'd2, A_OR = 5'd3, A_EQL = 5'd4;
    localparam logic [5:0] OP_R = 6'b000000, OP_ORI = 6'b001101, OP_LW = 6'b100011,
                           OP_SW = 6'b101011, OP_BEQ = 6'b000100, OP_J = 6'b000010,
                           OP_BAD = 6'b111111, FN_ADDU = 6'b100001, FN_SUBU = 6'b100011,
                           FN_BAD = 6'b000000;
    // Flags: {IRWrite, PCWrite, illegal, bus_err, suppress MemWrite}
    localparam logic [4:0] F_NONE = 5'b00000, F_IRPC = 5'b11000, F_PC = 5'b01000,
                           F_ILL = 5'b00100, F_BERR = 5'b00011;

    typedef struct packed {
        logic [3:0] st;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic [1:0] regdst;
        logic [1:0] datatoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [4:0] aluctrl;
        logic       illegal;
        logic       bus_err;
    } vec_t;

    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] cur_op = OP_R;
    logic [5:0] cur_fn = FN_ADDU;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic vec_t base(input logic [3:0] st, input logic [5:0] op, input logic [5:0] fn);
        vec_t e;
        e = '0;
        e.st = st;
        e.aluctrl = A_ADDU;
        case (st)
            S_FETCH:   begin e.memread = 1'b1; e.alusrcb = 2'b01; end
            S_DECODE:  begin e.alusrcb = 2'b11; e.extop = 1'b1; end
            S_EXEC_R:  begin e.alusrca = 1'b1; e.aluctrl = (fn == FN_SUBU) ? A_SUBU : A_ADDU; end
            S_EXEC_I:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.aluctrl = A_OR; end
            S_ALU_WB:  begin e.regwrite = 1'b1; e.regdst = (op == OP_R) ? 2'b01 : 2'b00; end
            S_MEM_ADR: begin e.alusrca = 1'b1; e.alusrcb = 2'b10; e.extop = 1'b1; end
            S_MEM_RD:  begin e.memread = 1'b1; e.iord = 1'b1; end
            S_MEM_WB:  begin e.regwrite = 1'b1; e.datatoreg = 2'b01; end
            S_MEM_WR:  begin e.memwrite = 1'b1; e.iord = 1'b1; end
            S_BRANCH:  begin e.alusrca = 1'b1; e.aluctrl = A_EQL; e.pcsrc = 2'b01; end
            S_JUMP:    e.pcsrc = 2'b10;
            default: ;
        endcase
        return e;
    endfunction

    function automatic vec_t sample();
        vec_t a;
        a.st        = bus.state;
        a.irwrite   = bus.IRWrite;
        a.pcwrite   = bus.PCWrite;
        a.pcsrc     = bus.PCSrc;
        a.iord      = bus.IorD;
        a.memread   = bus.MemRead;
        a.memwrite  = bus.MemWrite;
        a.regwrite  = bus.RegWrite;
        a.regdst    = bus.RegDst;
        a.datatoreg = bus.DatatoReg;
        a.alusrca   = bus.ALUSrcA;
        a.alusrcb   = bus.ALUSrcB;
        a.extop     = bus.ExtOp;
        a.aluctrl   = bus.ALUCtrl;
        a.illegal   = bus.illegal;
        a.bus_err   = bus.bus_err;
        return a;
    endfunction

    // One cycle: drive inputs, queue the expected word, advance to just after the next edge.
    task automatic cyc(input string tag, input logic [3:0] st, input logic mr, input logic z,
                       input logic [4:0] fl);
        exp_t e;
        bus.mem_ready = mr;
        bus.zero      = z;
        bus.opcode    = cur_op;
        bus.func      = cur_fn;
        e.tag = tag;
        e.v   = base(st, cur_op, cur_fn);
        e.v.irwrite = fl[4];
        e.v.pcwrite = fl[3];
        e.v.illegal = fl[2];
        e.v.bus_err = fl[1];
        if (fl[0]) e.v.memwrite = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic set_insn(input logic [5:0] op, input logic [5:0] fn);
        cur_op = op;
        cur_fn = fn;
    endtask

    always @(negedge clk) begin
        exp_t e;
        vec_t a;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            a = sample();
            n_cmp++;
            if (a !== e.v) begin
                n_bad++;
                $display("FAIL %s: got state=%0d word=%h, expected state=%0d word=%h",
                         e.tag, a.st, a, e.v.st, e.v);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b0;
        bus.opcode = OP_R;
        bus.func = FN_ADDU;
        @(posedge clk);
        #1;
        cyc("reset_hold", S_IDLE, 1'b1, 1'b0, F_NONE);
        rst = 1'b0;
        cyc("idle", S_IDLE, 1'b1, 1'b0, F_NONE);

        set_insn(OP_R, FN_ADDU);
        cyc("addu_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("addu_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("addu_exec", S_EXEC_R, 1'b1, 1'b0, F_NONE);
        cyc("addu_wb", S_ALU_WB, 1'b1, 1'b0, F_NONE);

        set_insn(OP_R, FN_SUBU);
        cyc("subu_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("subu_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("subu_exec", S_EXEC_R, 1'b1, 1'b0, F_NONE);
        cyc("subu_wb", S_ALU_WB, 1'b1, 1'b0, F_NONE);

        set_insn(OP_ORI, 6'b010101);
        cyc("ori_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("ori_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("ori_exec", S_EXEC_I, 1'b1, 1'b0, F_NONE);
        cyc("ori_wb", S_ALU_WB, 1'b1, 1'b0, F_NONE);

        set_insn(OP_LW, 6'b000100);
        cyc("lw_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("lw_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("lw_adr", S_MEM_ADR, 1'b1, 1'b0, F_NONE);
        for (int i = 0; i < 3; i++) cyc("lw_rd_wait", S_MEM_RD, 1'b0, 1'b0, F_NONE);
        cyc("lw_rd_done", S_MEM_RD, 1'b1, 1'b0, F_NONE);
        cyc("lw_wb", S_MEM_WB, 1'b1, 1'b0, F_NONE);

        set_insn(OP_BEQ, 6'b000000);
        cyc("beq1_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("beq1_dec", S_DECODE, 1'b1, 1'b1, F_NONE);
        cyc("beq_taken", S_BRANCH, 1'b1, 1'b1, F_PC);
        cyc("beq0_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("beq0_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("beq_not_taken", S_BRANCH, 1'b1, 1'b0, F_NONE);

        set_insn(OP_J, 6'b111000);
        cyc("j_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("j_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("j_jump", S_JUMP, 1'b1, 1'b0, F_PC);

        set_insn(OP_BAD, 6'b100001);
        cyc("ill_op_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("ill_op_dec", S_DECODE, 1'b1, 1'b0, F_ILL);
        set_insn(OP_R, FN_BAD);
        cyc("ill_fn_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("ill_fn_dec", S_DECODE, 1'b1, 1'b0, F_ILL);

        set_insn(OP_J, 6'b000000);
        cyc("fetch_wait", S_FETCH, 1'b0, 1'b0, F_NONE);
        cyc("fetch_wait", S_FETCH, 1'b0, 1'b0, F_NONE);
        cyc("fetch_late", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("j2_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("j2_jump", S_JUMP, 1'b1, 1'b0, F_PC);

        set_insn(OP_SW, 6'b001000);
        cyc("sw_to_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("sw_to_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("sw_to_adr", S_MEM_ADR, 1'b1, 1'b0, F_NONE);
        for (int i = 0; i < 15; i++) cyc("sw_to_wait", S_MEM_WR, 1'b0, 1'b0, F_NONE);
        cyc("sw_timeout", S_MEM_WR, 1'b0, 1'b0, F_BERR);
        cyc("sw_to_idle", S_IDLE, 1'b1, 1'b0, F_NONE);

        cyc("sw_late_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("sw_late_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("sw_late_adr", S_MEM_ADR, 1'b1, 1'b0, F_NONE);
        for (int i = 0; i < 15; i++) cyc("sw_late_wait", S_MEM_WR, 1'b0, 1'b0, F_NONE);
        cyc("sw_ready_at_limit", S_MEM_WR, 1'b1, 1'b0, F_NONE);

        cyc("sw_rst_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("sw_rst_dec", S_DECODE, 1'b1, 1'b0, F_NONE);
        cyc("sw_rst_adr", S_MEM_ADR, 1'b1, 1'b0, F_NONE);
        for (int i = 0; i < 4; i++) cyc("sw_rst_wait", S_MEM_WR, 1'b0, 1'b0, F_NONE);
        rst = 1'b1;
        cyc("sw_rst_edge", S_MEM_WR, 1'b0, 1'b0, F_NONE);
        rst = 1'b0;
        cyc("rst_idle", S_IDLE, 1'b0, 1'b0, F_NONE);
        // A fresh counter must tolerate a full 15 stalled fetch cycles without bus_err.
        for (int i = 0; i < 15; i++) cyc("post_rst_wait", S_FETCH, 1'b0, 1'b0, F_NONE);
        cyc("post_rst_fetch", S_FETCH, 1'b1, 1'b0, F_IRPC);
        cyc("post_rst_dec", S_DECODE, 1'b1, 1'b0, F_NONE);

        @(negedge clk);
        #1;
        if (n_cmp == 0) begin
            n_bad++;
            $display("FAIL monitor: got %0d comparisons, expected more than 0", n_cmp);
        end
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard: got %0d unchecked entries, expected 0", sb.size());
        end
        if (n_bad != 0)
            $display("FAIL summary: got %0d mismatches, expected 0", n_bad);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
